// File: rtl/activation_pipeline.sv
// -----------------------------------------------------------------------------
// activation_pipeline
//
// Applies a per-beat activation to a packed vector of LANES independent signed
// lanes. There are two register stages with valid/ready handshaking: S1 captures
// the beat, and S2 holds the computed result. A saturating counter tallies the
// negative input elements of every accepted beat.
//
// Ports
//   clk        : single rising-edge clock
//   rst        : synchronous active-high reset
//   in_valid   : input beat valid
//   in_ready   : a beat is accepted when in_valid && in_ready
//   in_data    : LANES x WIDTH packed input, lane i at [i*WIDTH +: WIDTH]
//   in_mode    : 00 pass, 01 ReLU, 10 leaky (x >>> LEAK_SHIFT), 11 clamped ReLU
//   clip_val   : signed upper bound for mode 11 (a negative value means 0)
//   out_valid  : output beat valid
//   out_ready  : downstream accepts the beat
//   out_data   : LANES x WIDTH packed results, same lane layout as in_data
//   clr_stats  : synchronous clear of neg_count
//   neg_count  : saturating count of negative input elements
// -----------------------------------------------------------------------------
module activation_pipeline #(
  parameter int WIDTH      = 16,
  parameter int LANES      = 4,
  parameter int LEAK_SHIFT = 3,
  parameter int CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic [1:0]             in_mode,
  input  logic [WIDTH-1:0]       clip_val,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  input  logic                   clr_stats,
  output logic [CNT_W-1:0]       neg_count
);

  typedef enum logic [1:0] {
    MODE_PASS  = 2'b00,
    MODE_RELU  = 2'b01,
    MODE_LEAKY = 2'b10,
    MODE_CLAMP = 2'b11
  } mode_e;

  // Width of the per-beat negative-lane count, and of the saturation sum.
  // The sum is one bit wider than either operand so that overflow is visible.
  localparam int NW = $clog2(LANES + 1);
  localparam int SW = ((CNT_W > NW) ? CNT_W : NW) + 1;

  // Activation of one lane. The comparisons operate on signed values.
  function automatic logic [WIDTH-1:0] act_lane(
    input logic [WIDTH-1:0] x,
    input mode_e            mode,
    input logic [WIDTH-1:0] clip
  );
    logic signed [WIDTH-1:0] xs;
    logic signed [WIDTH-1:0] relu;
    logic signed [WIDTH-1:0] cap;
    xs   = signed'(x);
    relu = x[WIDTH-1] ? '0 : xs;
    cap  = clip[WIDTH-1] ? '0 : signed'(clip);
    case (mode)
      MODE_PASS:  act_lane = x;
      MODE_RELU:  act_lane = relu;
      MODE_LEAKY: act_lane = x[WIDTH-1] ? (xs >>> LEAK_SHIFT) : xs;
      MODE_CLAMP: act_lane = (relu > cap) ? cap : relu;
      default:    act_lane = x;
    endcase
  endfunction

  // Stage registers
  logic                   r_v1;
  logic [LANES*WIDTH-1:0] r_d1;
  mode_e                  r_m1;
  logic [WIDTH-1:0]       r_c1;
  logic                   r_v2;
  logic [LANES*WIDTH-1:0] r_d2;
  logic [CNT_W-1:0]       r_neg_count;

  // Handshake wires
  logic w_rdy2;
  logic w_rdy1;
  logic w_acc;

  // Datapath and statistics wires
  logic [LANES*WIDTH-1:0] w_result;
  logic [NW-1:0]          w_neg_lanes;
  logic [CNT_W-1:0]       w_cnt_base;
  logic [SW-1:0]          w_sum;
  logic [CNT_W-1:0]       w_cnt_sat;

  // Ready propagates backward: a stage can take new data if it is empty or
  // its contents leave this cycle. This collapses bubbles.
  assign w_rdy2   = !r_v2 || out_ready;
  assign w_rdy1   = !r_v1 || w_rdy2;
  // While in reset the pipeline is treated as empty, but nothing is accepted.
  assign in_ready = rst || w_rdy1;
  assign w_acc    = in_valid && w_rdy1 && !rst;

  // NOTE: always_comb outputs get a default before the loop so that no path
  // leaves them unassigned, which would otherwise infer latches.
  always_comb begin
    w_result = '0;
    for (int i = 0; i < LANES; i++) begin
      w_result[i*WIDTH +: WIDTH] = act_lane(r_d1[i*WIDTH +: WIDTH], r_m1, r_c1);
    end
  end

  // Count the sign bits of the incoming beat. A same-cycle clear drops the
  // old total, so the register then loads only this beat's count.
  always_comb begin
    w_neg_lanes = '0;
    for (int i = 0; i < LANES; i++) begin
      w_neg_lanes = w_neg_lanes + NW'(in_data[i*WIDTH + WIDTH - 1]);
    end
    w_cnt_base = clr_stats ? '0 : r_neg_count;
    w_sum      = SW'(w_cnt_base) + SW'(w_neg_lanes);
    w_cnt_sat  = (|w_sum[SW-1:CNT_W]) ? '1 : w_sum[CNT_W-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so that every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1 <= 1'b0;
    end else if (w_rdy1) begin
      r_v1 <= in_valid;
    end
  end

  // NOTE: the S1 payload carries no reset because r_v1 qualifies it; only
  // the control bits and the visible outputs need a known reset state.
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_d1 <= in_data;
      r_m1 <= mode_e'(in_mode);
      r_c1 <= clip_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v2 <= 1'b0;
      r_d2 <= '0;
    end else if (w_rdy2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_d2 <= w_result;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_neg_count <= '0;
    end else if (w_acc) begin
      r_neg_count <= w_cnt_sat;
    end else if (clr_stats) begin
      r_neg_count <= '0;
    end
  end

  assign out_valid = r_v2;
  assign out_data  = r_d2;
  assign neg_count = r_neg_count;

endmodule

// File: tb/tb_activation_pipeline.sv
// -----------------------------------------------------------------------------
// tb_activation_pipeline
//
// Directed bench for activation_pipeline (WIDTH=16, LANES=4, LEAK_SHIFT=3,
// CNT_W=4). Inputs are driven 1 time unit after each rising edge, and outputs
// are sampled at the same point. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_activation_pipeline;

  localparam int WIDTH = 16;
  localparam int LANES = 4;
  localparam int CNT_W = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*WIDTH-1:0] in_data;
  logic [1:0]             in_mode;
  logic [WIDTH-1:0]       clip_val;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*WIDTH-1:0] out_data;
  logic                   clr_stats;
  logic [CNT_W-1:0]       neg_count;

  int checks   = 0;
  int failures = 0;

  activation_pipeline #(
    .WIDTH      (WIDTH),
    .LANES      (LANES),
    .LEAK_SHIFT (3),
    .CNT_W      (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .clip_val  (clip_val),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .clr_stats (clr_stats),
    .neg_count (neg_count)
  );

  always #5 clk = ~clk;

  // Lane 0 is the least significant lane.
  function automatic logic [63:0] pack4(input logic [15:0] l0, input logic [15:0] l1,
                                        input logic [15:0] l2, input logic [15:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] m, input logic [15:0] c,
                       input logic [63:0] d);
    in_valid = v;
    in_mode  = m;
    clip_val = c;
    in_data  = d;
  endtask

  logic [63:0] vin  [5];
  logic [63:0] vexp [5];
  logic [1:0]  vmode[5];
  logic [15:0] vclip[5];
  logic [63:0] beat_a, beat_b, beat_c;

  initial begin
    // ---------------- reset: offered beat must be ignored ----------------
    rst = 1'b1; clr_stats = 1'b0; out_ready = 1'b1;
    drive(1'b1, 2'b00, 16'h0000, pack4(16'h8000, 16'h8000, 16'h8000, 16'h8000));
    tick();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data",  out_data, 64'd0);
    check("rst_neg_count", 64'(neg_count), 64'd0);
    rst = 1'b0;
    drive(1'b0, 2'b00, 16'h0000, 64'd0);
    tick();
    check("post_rst_idle", 64'(out_valid), 64'd0);

    // ---------------- ReLU reference beat --------------------------------
    drive(1'b1, 2'b01, 16'h0000, pack4(16'h0123, 16'h0000, 16'h8123, 16'h7FFF));
    tick();
    drive(1'b0, 2'b00, 16'h0000, 64'd0);
    check("relu_lat1_valid", 64'(out_valid), 64'd0);
    check("relu_neg_count",  64'(neg_count), 64'd1);
    tick();
    check("relu_valid", 64'(out_valid), 64'd1);
    check("relu_data",  out_data, pack4(16'h0123, 16'h0000, 16'h0000, 16'h7FFF));
    tick();
    check("relu_drained", 64'(out_valid), 64'd0);

    // ---------------- back-to-back with per-beat mode switching ----------
    vin[0] = pack4(16'hFFFF, 16'hFFF0, 16'hFFF8, 16'd40); vmode[0] = 2'b10; vclip[0] = 16'd0;
    vexp[0] = pack4(16'hFFFF, 16'hFFFE, 16'hFFFF, 16'd40);
    vin[1] = pack4(16'hFFFB, 16'd3, 16'd6, 16'd100);      vmode[1] = 2'b11; vclip[1] = 16'd6;
    vexp[1] = pack4(16'd0, 16'd3, 16'd6, 16'd6);
    vin[2] = pack4(16'd5, 16'hFFFD, 16'h7FFF, 16'd1);     vmode[2] = 2'b11; vclip[2] = 16'hFFFC;
    vexp[2] = 64'd0;
    vin[3] = pack4(16'h8000, 16'd1, 16'hFFFE, 16'd3);     vmode[3] = 2'b00; vclip[3] = 16'd0;
    vexp[3] = pack4(16'h8000, 16'd1, 16'hFFFE, 16'd3);
    vin[4] = pack4(16'h8000, 16'hFFFF, 16'd2, 16'h7FFF);  vmode[4] = 2'b01; vclip[4] = 16'd0;
    vexp[4] = pack4(16'd0, 16'd0, 16'd2, 16'h7FFF);
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, vmode[k], vclip[k], vin[k]);
      check($sformatf("stream_in_ready_%0d", k), 64'(in_ready), 64'd1);
      tick();
      if (k >= 1) begin
        check($sformatf("stream_valid_%0d", k - 1), 64'(out_valid), 64'd1);
        check($sformatf("stream_data_%0d", k - 1), out_data, vexp[k-1]);
      end
    end
    drive(1'b0, 2'b00, 16'h0000, 64'd0);
    tick();
    check("stream_valid_4", 64'(out_valid), 64'd1);
    check("stream_data_4", out_data, vexp[4]);
    check("stream_neg_count", 64'(neg_count), 64'd10);
    tick();
    check("stream_drained", 64'(out_valid), 64'd0);

    // ---------------- backpressure ---------------------------------------
    beat_a = pack4(16'd1, 16'd2, 16'd3, 16'd4);
    beat_b = pack4(16'hFFFF, 16'd5, 16'd6, 16'd7);
    beat_c = pack4(16'd8, 16'd9, 16'd10, 16'd11);
    out_ready = 1'b0;
    drive(1'b1, 2'b00, 16'h0000, beat_a);
    tick();
    check("bp_ready_after_a", 64'(in_ready), 64'd1);
    drive(1'b1, 2'b00, 16'h0000, beat_b);
    tick();
    drive(1'b1, 2'b00, 16'h0000, beat_c);
    #1;
    check("bp_ready_low", 64'(in_ready), 64'd0);
    check("bp_head_a", out_data, beat_a);
    tick();
    check("bp_stall1_data", out_data, beat_a);
    check("bp_stall1_ready", 64'(in_ready), 64'd0);
    tick();
    check("bp_stall2_data",  out_data, beat_a);
    check("bp_stall2_valid", 64'(out_valid), 64'd1);
    check("bp_stall_neg",    64'(neg_count), 64'd11);
    out_ready = 1'b1;
    tick();
    drive(1'b0, 2'b00, 16'h0000, 64'd0);
    check("bp_drain_b", out_data, beat_b);
    tick();
    check("bp_drain_c", out_data, beat_c);
    check("bp_drain_c_valid", 64'(out_valid), 64'd1);
    tick();
    check("bp_drained", 64'(out_valid), 64'd0);

    // ---------------- counter clear and saturation -----------------------
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    check("clr_idle", 64'(neg_count), 64'd0);
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 2'b01, 16'h0000, pack4(16'h8000, 16'hFFFF, 16'hC000, 16'h8001));
      tick();
      check($sformatf("sat_count_%0d", k), 64'(neg_count), (k < 3) ? 64'((k + 1) * 4) : 64'd15);
    end
    clr_stats = 1'b1;
    drive(1'b1, 2'b00, 16'h0000, pack4(16'hFFFF, 16'd1, 16'hFFFE, 16'd2));
    tick();
    clr_stats = 1'b0;
    drive(1'b0, 2'b00, 16'h0000, 64'd0);
    check("clr_with_beat", 64'(neg_count), 64'd2);
    tick();
    tick();
    tick();
    check("sat_drained", 64'(out_valid), 64'd0);

    // ---------------- reset with two beats in flight ---------------------
    drive(1'b1, 2'b00, 16'h0000, pack4(16'd1, 16'd1, 16'd1, 16'd1));
    tick();
    drive(1'b1, 2'b00, 16'h0000, pack4(16'hFFFF, 16'd2, 16'd2, 16'd2));
    tick();
    check("inflight_valid", 64'(out_valid), 64'd1);
    check("inflight_neg", 64'(neg_count), 64'd3);
    out_ready = 1'b0;
    rst = 1'b1;
    drive(1'b1, 2'b00, 16'h0000, pack4(16'h8000, 16'h8000, 16'h8000, 16'h8000));
    #1;
    check("rst_forces_ready", 64'(in_ready), 64'd1);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 2'b00, 16'h0000, 64'd0);
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_data",  out_data, 64'd0);
    check("midrst_neg",   64'(neg_count), 64'd0);
    tick();
    check("midrst_no_stale", 64'(out_valid), 64'd0);
    drive(1'b1, 2'b10, 16'h0000, pack4(16'hFFF0, 16'd2, 16'd3, 16'd4));
    tick();
    drive(1'b0, 2'b00, 16'h0000, 64'd0);
    check("post_rst_lat1", 64'(out_valid), 64'd0);
    check("post_rst_neg",  64'(neg_count), 64'd1);
    tick();
    check("post_rst_valid", 64'(out_valid), 64'd1);
    check("post_rst_data",  out_data, pack4(16'hFFFE, 16'd2, 16'd3, 16'd4));
    tick();
    check("post_rst_drained", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
